key_debounce_filter: RTL and testbench
======================================

Name: key_debounce_filter

Overview:
- Conditions a raw mechanical key/switch input: two-flop synchronises it, rejects bounce, and presents a clean level.
- Sits directly upstream of the rising-edge detector; `key_level` drives the detector's input.
- Also reports filtering activity and a saturating count of rejected bounces for bring-up diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `key_raw` (legal 2..4).
- DEBOUNCE_CYCLES, 50000, consecutive differing samples required beyond the first before `key_level` changes (legal >= 1; 1 ms at 50 MHz).
- CNT_W, 16, width of the stability counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- RESET_LEVEL, 1'b1, idle/reset level of the key (pull-up keys idle high; matches the downstream detector's reset state).
- GLITCH_W, 8, width of `glitch_cnt`.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- key_raw  input  1  raw asynchronous key input
- glitch_clr  input  1  synchronous clear of `glitch_cnt`
- key_level  output  1  debounced key level; feeds the edge detector
- key_busy  output  1  high while a candidate transition is being qualified
- glitch_cnt  output  GLITCH_W  saturating count of aborted transitions

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
  - All synchroniser flops and `key_level` reset to RESET_LEVEL.
  - FSM resets to STABLE; counter and `glitch_cnt` reset to 0.
  - So after reset: `key_busy` = 0, `key_level` = RESET_LEVEL, `glitch_cnt` = 0.
- Synchroniser: a SYNC_STAGES-deep flop chain. `sync_out` is the last stage. No other logic touches `key_raw`.
- FSM state STABLE:
  - If `sync_out` != `key_level` at an edge: go to CHECK, counter <= 0.
  - Otherwise remain, counter held at 0.
- FSM state CHECK:
  - If `sync_out` == `key_level`: bounce rejected; go to STABLE, counter <= 0, `glitch_cnt` increments.
  - Else if counter == DEBOUNCE_CYCLES-1: `key_level` <= `sync_out`, go to STABLE, counter <= 0.
  - Else: counter increments.
- Qualification rule: `key_level` changes only after DEBOUNCE_CYCLES+1 consecutive edges with `sync_out` differing from it.
- Latency: with `key_raw` changing before edge 1 and held, `key_level` updates at edge SYNC_STAGES+1+DEBOUNCE_CYCLES.
- `key_busy`: registered state decode, = 1 exactly while in CHECK. It rises at edge SYNC_STAGES+1 and falls on the same edge `key_level` updates.
- `glitch_cnt`:
  - Saturates at all-ones and never wraps.
  - `glitch_clr` clears it; if a clear and an increment occur on the same edge, the clear wins (result 0).
- Both directions (press and release) are filtered identically. No separate edge output is produced here; edge generation is the downstream stage's job.
- Reset mid-CHECK: immediate return to reset values. A transition in progress is discarded and not counted as a glitch. After release, a held new level needs full synchroniser and debounce latency.
- `key_level` is glitch-free: it is driven directly from a flop, with no combinational path from `key_raw`.
- A pulse on `key_raw` shorter than one clock may be missed by the synchroniser. If it is captured, it is counted as a glitch.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=1, GLITCH_W=8):
- Reset/idle: assert rst_n low, then release with `key_raw`=1 for 100 cycles -> `key_level`=1, `key_busy`=0, `glitch_cnt`=0 throughout, including during reset.
- Clean press: `key_raw` 1->0 before edge 1, held -> `key_busy`=1 after edge 3; `key_level`=0 and `key_busy`=0 after edge 7. Release 0->1 held -> `key_level`=1 seven edges later.
- Bounce rejection: `key_raw`=0 for 3 cycles, then back to 1 -> `key_busy` pulses; `key_level` stays 1; `glitch_cnt`=1. Repeat with 4 low cycles -> still rejected; `glitch_cnt`=2.
- Saturation/clear: 300 rejected bounces -> `glitch_cnt`=255 and holds. Pulse `glitch_clr` on the same edge as a glitch increment -> `glitch_cnt`=0 next cycle.
- Reset mid-operation: `key_raw`=0, assert rst_n after edge 5 (in CHECK) -> `key_busy`=0 and `key_level`=1 immediately, `glitch_cnt` unchanged at 0. Release with `key_raw` still 0 -> `key_level`=0 after 7 edges.
- Downstream pairing: connect `key_level` to the rising-edge detector and run a bouncy press+release (5 bounces each) -> exactly one release-edge pulse and no spurious pulses.

Source files
------------

// File: rtl/key_debounce_filter.sv
// Key/switch conditioner: synchronises key_raw, qualifies level changes over
// DEBOUNCE_CYCLES+1 consecutive differing samples, and counts rejected bounces.
module key_debounce_filter #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 16,
  parameter logic RESET_LEVEL     = 1'b1,
  parameter int   GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_raw,
  input  logic                glitch_clr,
  output logic                key_level,
  output logic                key_busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  typedef enum logic {STABLE, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   glitch_evt;

  assign sync_out   = sync[SYNC_STAGES-1];
  assign glitch_evt = (state == CHECK) && (sync_out == key_level);

  // Presetting to the idle level keeps reset release from looking like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {SYNC_STAGES{RESET_LEVEL}};
    else        sync <= {sync[SYNC_STAGES-2:0], key_raw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STABLE;
      cnt       <= '0;
      key_level <= RESET_LEVEL;
      key_busy  <= 1'b0;
    end else begin
      case (state)
        STABLE: begin
          cnt <= '0;
          if (sync_out != key_level) begin
            state    <= CHECK;
            key_busy <= 1'b1;
          end
        end
        CHECK: begin
          if (sync_out == key_level) begin
            state    <= STABLE;
            key_busy <= 1'b0;
            cnt      <= '0;
          end else if (cnt == CNT_LAST) begin
            key_level <= sync_out;
            state     <= STABLE;
            key_busy  <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= STABLE;
          key_busy <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

  // Clear beats a coincident increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            glitch_cnt <= '0;
    else if (glitch_clr)                   glitch_cnt <= '0;
    else if (glitch_evt && ~&glitch_cnt)   glitch_cnt <= glitch_cnt + 1'b1;
  end

endmodule

// File: tb/tb_key_debounce_filter.sv
// Bench for key_debounce_filter: directed plan steps plus random key activity,
// checked every cycle against a run-length model of the qualification rule.
module tb_key_debounce_filter;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int GW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_raw;
  logic          glitch_clr;
  logic          key_level;
  logic          key_busy;
  logic [GW-1:0] glitch_cnt;

  int n_chk = 0;
  int n_pass = 0;

  // model state: delayed raw samples, current level, length of differing run, glitch count
  bit hist[$];
  bit m_level;
  int m_run;
  int m_glitch;
  // downstream rising-edge detector on key_level
  bit prev_lvl;
  int rises;

  key_debounce_filter #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(16),
    .RESET_LEVEL(1'b1), .GLITCH_W(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .glitch_clr(glitch_clr),
    .key_level(key_level), .key_busy(key_busy), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b1);
    m_level = 1'b1;
    m_run = 0;
    m_glitch = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, int'(key_level), int'(m_level));
    chk({tag, ".busy"}, int'(key_busy), (m_run > 0) ? 1 : 0);
    chk({tag, ".glitch"}, int'(glitch_cnt), m_glitch);
  endtask

  task automatic tick();
    bit s;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s = hist.pop_front();
      hist.push_back(key_raw);
      if (s != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = s;
          m_run = 0;
        end
        if (glitch_clr) m_glitch = 0;
      end else begin
        if (glitch_clr) m_glitch = 0;
        else if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    #1;
    if (key_level && !prev_lvl) rises++;
    prev_lvl = key_level;
    check_all("cyc");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b1;
    key_raw = 1'b1;
    glitch_clr = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check_all("in_reset");
    ticks(3);
    rst_n = 1'b1;
    ticks(100);
    check_all("idle");

    // clean press then release
    key_raw = 1'b0;
    ticks(2);
    chk("press.busy_e2", int'(key_busy), 0);
    tick();
    chk("press.busy_e3", int'(key_busy), 1);
    ticks(3);
    chk("press.level_e6", int'(key_level), 1);
    tick();
    chk("press.level_e7", int'(key_level), 0);
    chk("press.busy_e7", int'(key_busy), 0);
    ticks(5);
    key_raw = 1'b1;
    ticks(6);
    chk("release.level_e6", int'(key_level), 0);
    tick();
    chk("release.level_e7", int'(key_level), 1);
    ticks(5);

    // bounces of 3 and 4 low cycles are both rejected
    key_raw = 1'b0; ticks(3); key_raw = 1'b1; ticks(10);
    chk("bounce3.glitch", int'(glitch_cnt), 1);
    chk("bounce3.level", int'(key_level), 1);
    key_raw = 1'b0; ticks(4); key_raw = 1'b1; ticks(10);
    chk("bounce4.glitch", int'(glitch_cnt), 2);
    chk("bounce4.level", int'(key_level), 1);

    // saturation
    for (int i = 0; i < 300; i++) begin
      key_raw = 1'b0; ticks(2); key_raw = 1'b1; ticks(6);
    end
    chk("sat.glitch", int'(glitch_cnt), 255);
    // clear coincident with a glitch increment (increment lands on edge 6)
    key_raw = 1'b0; ticks(3); key_raw = 1'b1; ticks(2);
    chk("clr.busy_before", int'(key_busy), 1);
    glitch_clr = 1'b1; tick(); glitch_clr = 1'b0;
    chk("clr.glitch", int'(glitch_cnt), 0);
    ticks(5);

    // reset while qualifying a press
    key_raw = 1'b0;
    ticks(5);
    chk("midrst.busy_pre", int'(key_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.busy", int'(key_busy), 0);
    chk("midrst.level", int'(key_level), 1);
    chk("midrst.glitch", int'(glitch_cnt), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(6);
    chk("midrst.level_e6", int'(key_level), 1);
    tick();
    chk("midrst.level_e7", int'(key_level), 0);
    key_raw = 1'b1;
    ticks(10);

    // random key activity with occasional clears
    for (int i = 0; i < 400; i++) begin
      key_raw = 1'($urandom_range(0, 1));
      for (int j = 0; j < int'($urandom_range(1, 9)); j++) begin
        glitch_clr = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    glitch_clr = 1'b0;
    key_raw = 1'b1;
    ticks(12);

    // bouncy press and release through the downstream rising-edge detector
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      key_raw = 1'b0; ticks(2); key_raw = 1'b1; ticks(2);
    end
    key_raw = 1'b0; ticks(12);
    chk("pair.pressed", int'(key_level), 0);
    chk("pair.no_spurious", rises, 0);
    for (int i = 0; i < 5; i++) begin
      key_raw = 1'b1; ticks(2); key_raw = 1'b0; ticks(2);
    end
    key_raw = 1'b1; ticks(12);
    chk("pair.released", int'(key_level), 1);
    chk("pair.one_rise", rises, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
